// File: rtl/uart_stream_buffer.sv
// uart_stream_buffer
//   Buffers words between a byte-level UART receiver/transmitter and the core's
//   stream interfaces.
//   RX path: UART receiver (i_rx_data/i_rx_strobe) -> RX FIFO -> core
//            (o_out_data/o_out_valid/i_out_ready, first-word-fall-through).
//   TX path: core (i_in_data/i_in_valid/o_in_ready) -> TX FIFO -> UART transmitter
//            (o_tx_data/o_tx_start, throttled by i_tx_busy).
//   Status:  o_rx_level, o_tx_level, o_rx_almost_full, sticky o_rx_overflow and a
//            saturating o_drop_count, cleared by i_clear_overflow.
//   Control: i_flush_rx / i_flush_tx empty one direction each.
//   clk rising edge; reset synchronous, active-high.
module uart_stream_buffer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned RX_AW        = 10,
    parameter int unsigned TX_AW        = 10,
    parameter int unsigned RX_AF_MARGIN = 16,
    parameter int unsigned DROP_CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_strobe,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_busy,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    input  logic                  i_flush_rx,
    input  logic                  i_flush_tx,
    input  logic                  i_clear_overflow,
    output logic [RX_AW:0]        o_rx_level,
    output logic [TX_AW:0]        o_tx_level,
    output logic                  o_rx_almost_full,
    output logic                  o_rx_overflow,
    output logic [DROP_CNT_W-1:0] o_drop_count
);

    localparam logic [RX_AW:0]        RX_DEPTH = {1'b1, {RX_AW{1'b0}}};
    localparam logic [TX_AW:0]        TX_DEPTH = {1'b1, {TX_AW{1'b0}}};
    localparam logic [DROP_CNT_W-1:0] DROP_MAX = {DROP_CNT_W{1'b1}};

    // ---------------------------------------------------------------- RX FIFO
    logic [DATA_WIDTH-1:0] r_rx_mem [0:(2**RX_AW)-1];
    logic [RX_AW-1:0]      r_rx_head, r_rx_tail;
    logic [RX_AW:0]        r_rx_count;
    logic                  r_rx_overflow;
    logic [DROP_CNT_W-1:0] r_drop_count;

    logic                  w_rx_full, w_rx_pop, w_rx_push, w_rx_drop;
    logic [RX_AW:0]        w_rx_free;

    assign w_rx_full = (r_rx_count == RX_DEPTH);
    assign w_rx_pop  = (r_rx_count != '0) && i_out_ready && !i_flush_rx;
    // A strobe while full still lands if a pop frees a slot in the same cycle.
    assign w_rx_push = i_rx_strobe && (!w_rx_full || w_rx_pop) && !i_flush_rx;
    // A push discarded by a flush is not a drop.
    assign w_rx_drop = i_rx_strobe && w_rx_full && !w_rx_pop && !i_flush_rx;
    assign w_rx_free = RX_DEPTH - r_rx_count;

    always_ff @(posedge clk) begin
        if (reset || i_flush_rx) begin
            r_rx_head  <= '0;
            r_rx_tail  <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_rx_push) r_rx_tail <= r_rx_tail + 1'b1;
            if (w_rx_pop)  r_rx_head <= r_rx_head + 1'b1;
            if (w_rx_push && !w_rx_pop)      r_rx_count <= r_rx_count + 1'b1;
            else if (!w_rx_push && w_rx_pop) r_rx_count <= r_rx_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rx_push && !reset) r_rx_mem[r_rx_tail] <= i_rx_data;
    end

    // A drop in the same cycle as a clear wins: flag stays set, count restarts at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_overflow <= 1'b0;
            r_drop_count  <= '0;
        end else if (w_rx_drop) begin
            r_rx_overflow <= 1'b1;
            if (i_clear_overflow)          r_drop_count <= {{(DROP_CNT_W-1){1'b0}}, 1'b1};
            else if (r_drop_count != DROP_MAX) r_drop_count <= r_drop_count + 1'b1;
        end else if (i_clear_overflow) begin
            r_rx_overflow <= 1'b0;
            r_drop_count  <= '0;
        end
    end

    assign o_out_data       = r_rx_mem[r_rx_head];
    assign o_out_valid      = (r_rx_count != '0);
    assign o_rx_level       = r_rx_count;
    assign o_rx_almost_full = (32'(w_rx_free) <= RX_AF_MARGIN);
    assign o_rx_overflow    = r_rx_overflow;
    assign o_drop_count     = r_drop_count;

    // ---------------------------------------------------------------- TX FIFO
    logic [DATA_WIDTH-1:0] r_tx_mem [0:(2**TX_AW)-1];
    logic [TX_AW-1:0]      r_tx_head, r_tx_tail;
    logic [TX_AW:0]        r_tx_count;
    logic                  r_tx_start;
    logic [DATA_WIDTH-1:0] r_tx_data;

    logic                  w_tx_push, w_tx_launch;

    assign o_in_ready  = (r_tx_count != TX_DEPTH);
    assign w_tx_push   = i_in_valid && o_in_ready && !i_flush_tx;
    // !r_tx_start leaves a gap cycle so the transmitter can raise tx_busy.
    assign w_tx_launch = !i_tx_busy && (r_tx_count != '0) && !r_tx_start && !i_flush_tx;

    always_ff @(posedge clk) begin
        if (reset || i_flush_tx) begin
            r_tx_head  <= '0;
            r_tx_tail  <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_tx_push)   r_tx_tail <= r_tx_tail + 1'b1;
            if (w_tx_launch) r_tx_head <= r_tx_head + 1'b1;
            if (w_tx_push && !w_tx_launch)      r_tx_count <= r_tx_count + 1'b1;
            else if (!w_tx_push && w_tx_launch) r_tx_count <= r_tx_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push && !reset) r_tx_mem[r_tx_tail] <= i_in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_start <= w_tx_launch;
            if (w_tx_launch) r_tx_data <= r_tx_mem[r_tx_head];
        end
    end

    assign o_tx_start = r_tx_start;
    assign o_tx_data  = r_tx_data;
    assign o_tx_level = r_tx_count;

endmodule

// File: tb/tb_uart_stream_buffer.sv
// Directed bench: dut_a uses default parameters, dut_b uses 4-deep FIFOs
// (RX_AW = TX_AW = 2, RX_AF_MARGIN = 1). Both share the same stimulus.
module tb_uart_stream_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data, in_data;
    logic       rx_strobe, tx_busy, in_valid, out_ready;
    logic       flush_rx, flush_tx, clear_overflow;

    logic [7:0]  tx_data_a, out_data_a, tx_data_b, out_data_b;
    logic        tx_start_a, in_ready_a, out_valid_a, af_a, ovf_a;
    logic        tx_start_b, in_ready_b, out_valid_b, af_b, ovf_b;
    logic [10:0] rx_level_a, tx_level_a;
    logic [2:0]  rx_level_b, tx_level_b;
    logic [15:0] drop_a, drop_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_stream_buffer dut_a (
        .clk(clk), .reset(reset),
        .i_rx_data(rx_data), .i_rx_strobe(rx_strobe),
        .o_tx_data(tx_data_a), .o_tx_start(tx_start_a), .i_tx_busy(tx_busy),
        .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready_a),
        .o_out_data(out_data_a), .o_out_valid(out_valid_a), .i_out_ready(out_ready),
        .i_flush_rx(flush_rx), .i_flush_tx(flush_tx), .i_clear_overflow(clear_overflow),
        .o_rx_level(rx_level_a), .o_tx_level(tx_level_a),
        .o_rx_almost_full(af_a), .o_rx_overflow(ovf_a), .o_drop_count(drop_a)
    );

    uart_stream_buffer #(
        .DATA_WIDTH(8), .RX_AW(2), .TX_AW(2), .RX_AF_MARGIN(1), .DROP_CNT_W(16)
    ) dut_b (
        .clk(clk), .reset(reset),
        .i_rx_data(rx_data), .i_rx_strobe(rx_strobe),
        .o_tx_data(tx_data_b), .o_tx_start(tx_start_b), .i_tx_busy(tx_busy),
        .i_in_data(in_data), .i_in_valid(in_valid), .o_in_ready(in_ready_b),
        .o_out_data(out_data_b), .o_out_valid(out_valid_b), .i_out_ready(out_ready),
        .i_flush_rx(flush_rx), .i_flush_tx(flush_tx), .i_clear_overflow(clear_overflow),
        .o_rx_level(rx_level_b), .o_tx_level(tx_level_b),
        .o_rx_almost_full(af_b), .o_rx_overflow(ovf_b), .o_drop_count(drop_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rx_data = '0; in_data = '0; rx_strobe = 0; tx_busy = 0;
        in_valid = 0; out_ready = 0; flush_rx = 0; flush_tx = 0; clear_overflow = 0;
        step(); step();
        reset = 1'b0;

        // ---- reset state
        chk("rst_rx_level", 32'(rx_level_a), 0);
        chk("rst_tx_level", 32'(tx_level_a), 0);
        chk("rst_out_valid", 32'(out_valid_a), 0);
        chk("rst_in_ready", 32'(in_ready_a), 1);
        chk("rst_tx_start", 32'(tx_start_a), 0);
        chk("rst_tx_data", 32'(tx_data_a), 0);
        chk("rst_overflow", 32'(ovf_a), 0);
        chk("rst_drop", 32'(drop_a), 0);
        chk("rst_af_a", 32'(af_a), 0);
        chk("rst_af_b", 32'(af_b), 0);

        // ---- RX fill then in-order drain (dut_a)
        for (int i = 0; i < 5; i++) begin
            rx_data = 8'(32'h11 + i); rx_strobe = 1; step();
        end
        rx_strobe = 0;
        chk("rx_level5", 32'(rx_level_a), 5);
        chk("rx_valid5", 32'(out_valid_a), 1);
        chk("rx_head5", 32'(out_data_a), 32'h11);
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            chk("rx_drain_valid", 32'(out_valid_a), 1);
            chk("rx_drain_data", 32'(out_data_a), 32'h11 + i);
            step();
        end
        out_ready = 0;
        chk("rx_empty_level", 32'(rx_level_a), 0);
        chk("rx_empty_valid", 32'(out_valid_a), 0);

        // ---- small RX: almost-full, overflow, full push+pop, clear (dut_b)
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rx_data = 8'(32'h21 + i); rx_strobe = 1; step();
            chk("b_rx_level", 32'(rx_level_b), i + 1);
            chk("b_af", 32'(af_b), (i >= 2) ? 1 : 0);
        end
        rx_data = 8'hEE; step(); step();
        rx_strobe = 0;
        chk("b_ovf", 32'(ovf_b), 1);
        chk("b_drop2", 32'(drop_b), 2);
        chk("b_level_full", 32'(rx_level_b), 4);
        rx_data = 8'h25; rx_strobe = 1; out_ready = 1; step();
        rx_strobe = 0; out_ready = 0;
        chk("b_pushpop_drop", 32'(drop_b), 2);
        chk("b_pushpop_level", 32'(rx_level_b), 4);
        chk("b_pushpop_head", 32'(out_data_b), 32'h22);
        clear_overflow = 1; step(); clear_overflow = 0;
        chk("b_clr_ovf", 32'(ovf_b), 0);
        chk("b_clr_drop", 32'(drop_b), 0);
        // Drop and clear together: drop wins
        rx_data = 8'hEE; rx_strobe = 1; clear_overflow = 1; step();
        rx_strobe = 0; clear_overflow = 0;
        chk("b_clrdrop_ovf", 32'(ovf_b), 1);
        chk("b_clrdrop_cnt", 32'(drop_b), 1);
        // Drain across the pointer wrap
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("b_wrap_data", 32'(out_data_b), 32'h22 + i);
            step();
        end
        out_ready = 0;
        chk("b_wrap_empty", 32'(out_valid_b), 0);

        // ---- TX launch spacing (dut_a)
        do_reset();
        tx_busy = 0;
        in_data = 8'hA5; in_valid = 1; step();
        in_data = 8'h5A; step();
        in_valid = 0;
        chk("tx_start1", 32'(tx_start_a), 1);
        chk("tx_data1", 32'(tx_data_a), 32'hA5);
        step();
        chk("tx_gap", 32'(tx_start_a), 0);
        chk("tx_gap_level", 32'(tx_level_a), 1);
        step();
        chk("tx_start2", 32'(tx_start_a), 1);
        chk("tx_data2", 32'(tx_data_a), 32'h5A);
        chk("tx_level0", 32'(tx_level_a), 0);
        step();
        chk("tx_idle", 32'(tx_start_a), 0);
        tx_busy = 1;
        in_data = 8'hA5; in_valid = 1; step();
        chk("tx_busy_start_a", 32'(tx_start_a), 0);
        in_data = 8'h5A; step();
        in_valid = 0;
        chk("tx_busy_start_b", 32'(tx_start_a), 0);
        step(); step();
        chk("tx_busy_start_c", 32'(tx_start_a), 0);
        chk("tx_busy_level", 32'(tx_level_a), 2);

        // ---- small TX full / in_ready (dut_b)
        do_reset();
        tx_busy = 1; in_valid = 1;
        for (int i = 0; i < 6; i++) begin
            chk("b_in_ready", 32'(in_ready_b), (i < 4) ? 1 : 0);
            in_data = 8'(32'h30 + i); step();
        end
        in_valid = 0;
        chk("b_tx_full_level", 32'(tx_level_b), 4);
        chk("b_tx_full_ready", 32'(in_ready_b), 0);
        tx_busy = 0; step(); tx_busy = 1;
        chk("b_tx_launch", 32'(tx_start_b), 1);
        chk("b_tx_launch_data", 32'(tx_data_b), 32'h30);
        chk("b_tx_level3", 32'(tx_level_b), 3);
        chk("b_tx_ready_back", 32'(in_ready_b), 1);

        // ---- flush_rx with concurrent strobe (dut_b)
        do_reset();
        for (int i = 0; i < 3; i++) begin
            rx_data = 8'(32'h40 + i); rx_strobe = 1; step();
        end
        flush_rx = 1; rx_data = 8'h43; step();
        flush_rx = 0; rx_strobe = 0;
        chk("b_flush_level", 32'(rx_level_b), 0);
        chk("b_flush_valid", 32'(out_valid_b), 0);
        chk("b_flush_drop", 32'(drop_b), 0);
        // Flush while full with strobe: not a drop
        for (int i = 0; i < 4; i++) begin
            rx_data = 8'(32'h50 + i); rx_strobe = 1; step();
        end
        flush_rx = 1; step();
        flush_rx = 0; rx_strobe = 0;
        chk("b_flushfull_drop", 32'(drop_b), 0);
        chk("b_flushfull_ovf", 32'(ovf_b), 0);

        // ---- flush_tx suppresses launch (dut_b)
        tx_busy = 1; in_valid = 1; in_data = 8'h61; step(); step();
        in_valid = 0;
        tx_busy = 0; flush_tx = 1; step();
        flush_tx = 0; tx_busy = 1;
        chk("b_flushtx_start", 32'(tx_start_b), 0);
        chk("b_flushtx_level", 32'(tx_level_b), 0);

        // ---- reset mid-drain (dut_b)
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(32'h70 + i); step();
        end
        in_valid = 0;
        rx_data = 8'h77; rx_strobe = 1; step(); rx_strobe = 0;
        tx_busy = 0; step();
        chk("b_middrain_start", 32'(tx_start_b), 1);
        reset = 1; step(); reset = 0;
        chk("b_mid_rst_start", 32'(tx_start_b), 0);
        chk("b_mid_rst_txlvl", 32'(tx_level_b), 0);
        chk("b_mid_rst_rxlvl", 32'(rx_level_b), 0);
        chk("b_mid_rst_txdata", 32'(tx_data_b), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
